hyperspace_frame_sequencer: RTL and testbench
=============================================

# hyperspace_frame_sequencer

Frame-level controller placed between the GPIO-mapped input/output streams and the spectrometer datapath. It admits exactly one input frame of IN_LEN 8-bit samples, forces the frame's `last` marker, and gates/counts the OUT_LEN 16-bit result samples back to the pads. It reports done, error and frame-count status to the management SoC. It owns frame boundaries so that a misbehaving external source cannot desynchronise the datapath.

## Interface
- IN_W, 8, input sample width
- OUT_W, 16, output sample width
- IN_LEN, 2048, input samples per frame
- OUT_LEN, 1536, output samples per frame
- CNT_W, 16, width of all counters
- TIMEOUT, 4096, idle cycles allowed in DRAIN before watchdog fires
- clock  in  1  system clock; all logic on rising edge
- RSTB  in  1  reset, synchronous, active-high
- cfg_start  in  1  one-cycle pulse; arms one frame from IDLE
- cfg_continuous  in  1  1 = re-arm automatically after DONE
- cfg_abort  in  1  one-cycle pulse; returns to IDLE from any state
- s_in_valid / s_in_ready / s_in_data[IN_W] / s_in_last  in/out/in/in  pad input stream
- m_dp_valid / m_dp_ready / m_dp_data[IN_W] / m_dp_last  out/in/out/out  to datapath
- s_dp_valid / s_dp_ready / s_dp_data[OUT_W] / s_dp_last  in/out/in/in  from datapath
- m_out_valid / m_out_ready / m_out_data[OUT_W] / m_out_last  out/in/out/out  pad output stream
- busy  out  1  state is LOAD or DRAIN
- done  out  1  one-cycle pulse on frame completion
- err_len  out  1  sticky: s_in_last disagreed with the internal count
- err_timeout  out  1  sticky: watchdog fired
- frame_cnt  out  CNT_W  completed frames; wraps from 0xFFFF to 0

## Operation
- States: IDLE, LOAD, DRAIN, DONE. Reset state is IDLE.
- IDLE:
  - All ready/valid outputs are 0.
  - cfg_start moves the block to LOAD, clears in_cnt and out_cnt, and clears err_len and err_timeout.
- LOAD, input path (combinational pass-through):
  - m_dp_valid = s_in_valid.
  - s_in_ready = m_dp_ready.
  - m_dp_data = s_in_data.
  - m_dp_last = (in_cnt == IN_LEN-1).
- Input handshake: an input handshake is m_dp_valid & m_dp_ready. Each handshake increments in_cnt.
- err_len is set on a handshake where s_in_last != (in_cnt == IN_LEN-1). The frame still ends on the internal count.
- Output path, active in LOAD and DRAIN:
  - m_out_valid = s_dp_valid.
  - s_dp_ready = m_out_ready.
  - m_out_data = s_dp_data.
  - m_out_last = (out_cnt == OUT_LEN-1).
- Output handshake: each output handshake increments out_cnt. s_dp_last is ignored.
- Transitions from LOAD:
  - Input handshake with in_cnt == IN_LEN-1 → DRAIN.
  - If the output frame also completes in the same cycle (or has already completed) → DONE directly.
- DRAIN: input side is gated (s_in_ready = 0, m_dp_valid = 0). An output handshake with out_cnt == OUT_LEN-1 → DONE.
- Output samples beyond OUT_LEN are never accepted: s_dp_ready = 0 once out_cnt reaches OUT_LEN.
- DONE (one cycle):
  - done = 1 and frame_cnt increments.
  - Next state is LOAD (counters cleared) if cfg_continuous, otherwise IDLE.
  - All stream ready/valid outputs are 0.
- cfg_abort:
  - Takes priority over every other transition.
  - Next state is IDLE and counters clear.
  - Sticky errors and frame_cnt are kept; done is not asserted.
- cfg_start outside IDLE is ignored.

## Timing
- Data paths are zero latency: purely combinational gating, no buffering.
- Reset values:
  - State IDLE; in_cnt, out_cnt, wd_cnt and frame_cnt all 0.
  - busy, done, err_len and err_timeout all 0.
  - All ready/valid outputs 0.
- State changes take effect one cycle after the qualifying handshake edge.
- The last input handshake and the first DRAIN cycle are adjacent.
- done asserts in the cycle after the final output handshake.
- RSTB asserted mid-frame aborts immediately, same as reset; counters are not preserved.
- Minimum frame period in continuous mode: IN_LEN cycles plus 1 DONE cycle, assuming outputs complete no later than the last input.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - wd_cnt clears on every output handshake and on entry to DRAIN, and counts every other DRAIN cycle.
  - When wd_cnt == TIMEOUT-1: err_timeout sets, the state goes to IDLE, and no done pulse is issued.
- SEQ_TIMEOUT_EN undefined: wd_cnt is absent, err_timeout is tied 0, and DRAIN waits indefinitely.

## Test plan
- Nominal frame: reset, pulse cfg_start, stream 2048 bytes with s_in_last on byte 2047, datapath returns 1536 words.
  - m_dp_last exactly on handshake 2047 and m_out_last on word 1535.
  - done pulses once; frame_cnt = 1; all data bit-exact vs the golden file.
- Backpressure: random m_dp_ready and m_out_ready at 50%.
  - Same counts and data as the nominal frame.
  - No handshake while the corresponding ready = 0.
- Length error: s_in_last asserted on byte 1000.
  - err_len = 1; m_dp_last still only on byte 2047; frame completes with done.
- Continuous mode: cfg_continuous = 1, three frames back-to-back.
  - frame_cnt = 3, DONE lasts 1 cycle each time, and byte 0 of the next frame is accepted in the cycle after DONE.
- Abort and reset mid-frame:
  - cfg_abort after 500 input bytes → IDLE next cycle, s_in_ready = 0, frame_cnt unchanged.
  - RSTB at word 700 of DRAIN → all outputs return to their reset values.
- Watchdog (SEQ_TIMEOUT_EN defined): datapath stalls after 100 output words.
  - err_timeout = 1 exactly 4096 DRAIN cycles after the last handshake; state IDLE; done never asserted.
  - Without the macro the block remains in DRAIN.

Source files
------------

// File: rtl/hyperspace_frame_sequencer_if.sv
// Stream bundle around the frame sequencer: pad input, datapath in/out and pad output.
// master = sequencer side, slave = surrounding pads/datapath.
interface hyperspace_frame_sequencer_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
);
  logic             s_in_valid;
  logic             s_in_ready;
  logic [IN_W-1:0]  s_in_data;
  logic             s_in_last;

  logic             m_dp_valid;
  logic             m_dp_ready;
  logic [IN_W-1:0]  m_dp_data;
  logic             m_dp_last;

  logic             s_dp_valid;
  logic             s_dp_ready;
  logic [OUT_W-1:0] s_dp_data;
  logic             s_dp_last;

  logic             m_out_valid;
  logic             m_out_ready;
  logic [OUT_W-1:0] m_out_data;
  logic             m_out_last;

  modport master (
    input  s_in_valid, s_in_data, s_in_last, m_dp_ready,
    input  s_dp_valid, s_dp_data, s_dp_last, m_out_ready,
    output s_in_ready, m_dp_valid, m_dp_data, m_dp_last,
    output s_dp_ready, m_out_valid, m_out_data, m_out_last
  );

  modport slave (
    output s_in_valid, s_in_data, s_in_last, m_dp_ready,
    output s_dp_valid, s_dp_data, s_dp_last, m_out_ready,
    input  s_in_ready, m_dp_valid, m_dp_data, m_dp_last,
    input  s_dp_ready, m_out_valid, m_out_data, m_out_last
  );
endinterface

// File: rtl/hyperspace_frame_sequencer.sv
// Frame sequencer: admits one IN_LEN input frame, gates OUT_LEN results back to the pads.
// Optional DRAIN watchdog enabled by defining SEQ_TIMEOUT_EN.
module hyperspace_frame_sequencer #(
  parameter int IN_LEN  = 2048,
  parameter int OUT_LEN = 1536,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                         clock,
  input  logic                         RSTB,
  input  logic                         cfg_start,
  input  logic                         cfg_continuous,
  input  logic                         cfg_abort,
  hyperspace_frame_sequencer_if.master bus,
  output logic                         busy,
  output logic                         done,
  output logic                         err_len,
  output logic                         err_timeout,
  output logic [CNT_W-1:0]             frame_cnt
);

  if (IN_LEN < 1 || OUT_LEN < 1 || TIMEOUT < 1 ||
      IN_LEN >= 2**CNT_W || OUT_LEN >= 2**CNT_W || TIMEOUT > 2**CNT_W) begin : g_bad_params
    $error("hyperspace_frame_sequencer: frame lengths and TIMEOUT must fit in CNT_W");
  end

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_e;

  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_LEN - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_LEN - 1);
  localparam logic [CNT_W-1:0] OUT_FULL = CNT_W'(OUT_LEN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_len_q, err_len_d;

  logic load_en, out_en, in_last, out_last, in_hs, out_hs, out_done_now;

  // The datapath's own end marker is ignored; frame boundaries come from out_cnt.
  logic unused_dp_last;
  assign unused_dp_last = bus.s_dp_last;

  assign load_en  = (state_q == LOAD);
  assign out_en   = (state_q == LOAD || state_q == DRAIN) && (out_cnt_q != OUT_FULL);
  assign in_last  = (in_cnt_q == IN_LAST);
  assign out_last = (out_cnt_q == OUT_LAST);

  assign bus.m_dp_valid  = load_en & bus.s_in_valid;
  assign bus.s_in_ready  = load_en & bus.m_dp_ready;
  assign bus.m_dp_data   = bus.s_in_data;
  assign bus.m_dp_last   = load_en & in_last;

  assign bus.m_out_valid = out_en & bus.s_dp_valid;
  assign bus.s_dp_ready  = out_en & bus.m_out_ready;
  assign bus.m_out_data  = bus.s_dp_data;
  assign bus.m_out_last  = out_en & out_last;

  assign in_hs        = bus.m_dp_valid & bus.m_dp_ready;
  assign out_hs       = bus.m_out_valid & bus.m_out_ready;
  assign out_done_now = (out_cnt_q == OUT_FULL) | (out_hs & out_last);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             err_timeout_q, err_timeout_d;
`endif

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    frame_cnt_d = frame_cnt_q;
    err_len_d   = err_len_q;
`ifdef SEQ_TIMEOUT_EN
    err_timeout_d = err_timeout_q;
`endif

    if (in_hs)  in_cnt_d  = in_cnt_q + 1'b1;
    if (out_hs) out_cnt_d = out_cnt_q + 1'b1;
    if (in_hs && (bus.s_in_last != in_last)) err_len_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cfg_start) begin
          state_d   = LOAD;
          err_len_d = 1'b0;
`ifdef SEQ_TIMEOUT_EN
          err_timeout_d = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (in_hs && in_last) state_d = out_done_now ? DONE : DRAIN;
      end
      DRAIN: begin
        if (out_hs && out_last) begin
          state_d = DONE;
`ifdef SEQ_TIMEOUT_EN
        end else if (!out_hs && wd_cnt_q == WD_LAST) begin
          state_d       = IDLE;
          err_timeout_d = 1'b1;
`endif
        end
      end
      DONE: state_d = cfg_continuous ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase

    if (cfg_abort) state_d = IDLE;

    // Counters restart whenever a frame is (re)armed or abandoned.
    if (state_d == IDLE || (state_d == LOAD && state_q != LOAD)) begin
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
    if (state_d == DONE) frame_cnt_d = frame_cnt_q + 1'b1;

`ifdef SEQ_TIMEOUT_EN
    wd_cnt_d = (state_q == DRAIN && state_d == DRAIN && !out_hs) ? wd_cnt_q + 1'b1 : '0;
`endif

    busy_d = (state_d == LOAD) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (RSTB) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      frame_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_cnt_q   <= out_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_len_q   <= err_len_d;
`ifdef SEQ_TIMEOUT_EN
      wd_cnt_q      <= wd_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err_len   = err_len_q;
  assign frame_cnt = frame_cnt_q;
`ifdef SEQ_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hyperspace_frame_sequencer.sv
// Randomized self-checking bench for hyperspace_frame_sequencer; a frame-level model
// (sample counts per frame, pending-done flag, sticky flags) predicts every output each cycle.
module tb_hyperspace_frame_sequencer;
  localparam int IN_LEN  = 2048;
  localparam int OUT_LEN = 1536;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 4096;

  logic             clock = 1'b0;
  logic             RSTB;
  logic             cfg_start, cfg_continuous, cfg_abort;
  logic             busy, done, err_len, err_timeout;
  logic [CNT_W-1:0] frame_cnt;

  hyperspace_frame_sequencer_if #(.IN_W(8), .OUT_W(16)) bus ();

  hyperspace_frame_sequencer #(
    .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .RSTB(RSTB),
    .cfg_start(cfg_start), .cfg_continuous(cfg_continuous), .cfg_abort(cfg_abort),
    .bus(bus),
    .busy(busy), .done(done), .err_len(err_len), .err_timeout(err_timeout),
    .frame_cnt(frame_cnt)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Stimulus knobs: percent probability of each valid/ready, plus one-shot requests.
  int p_iv = 100, p_dr = 100, p_ov = 100, p_or = 100;
  int last_pos = IN_LEN - 1;
  bit req_start, req_abort, req_rst, cont, chk_en;

  // Frame-level reference model.
  bit m_active, m_done, m_err_len, m_err_to;
  int m_in, m_out, m_wd, m_frames;
  int done_pulses;
  bit seen_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit load, oen, in_hs, out_hs, was_drain;
    @(negedge clock);
    RSTB           = req_rst;
    cfg_start      = req_start;
    cfg_abort      = req_abort;
    cfg_continuous = cont;
    bus.s_in_valid  = ($urandom_range(99) < p_iv);
    bus.s_in_data   = 8'($urandom);
    bus.s_in_last   = (m_in == last_pos);
    bus.m_dp_ready  = ($urandom_range(99) < p_dr);
    bus.s_dp_valid  = ($urandom_range(99) < p_ov);
    bus.s_dp_data   = 16'($urandom);
    bus.s_dp_last   = 1'($urandom);
    bus.m_out_ready = ($urandom_range(99) < p_or);
    #1;
    load = m_active && (m_in < IN_LEN);
    oen  = m_active && (m_out < OUT_LEN);
    if (chk_en) begin
      check("s_in_ready", bus.s_in_ready, load && bus.m_dp_ready);
      check("m_dp_valid", bus.m_dp_valid, load && bus.s_in_valid);
      if (load) begin
        check("m_dp_last", bus.m_dp_last, m_in == IN_LEN - 1);
        check("m_dp_data", bus.m_dp_data, bus.s_in_data);
      end
      check("s_dp_ready", bus.s_dp_ready, oen && bus.m_out_ready);
      check("m_out_valid", bus.m_out_valid, oen && bus.s_dp_valid);
      if (oen) begin
        check("m_out_last", bus.m_out_last, m_out == OUT_LEN - 1);
        check("m_out_data", bus.m_out_data, bus.s_dp_data);
      end
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("err_len", err_len, m_err_len);
      check("err_timeout", err_timeout, m_err_to);
      check("frame_cnt", frame_cnt, 32'(m_frames & 32'hFFFF));
    end
    if (done === 1'b1) begin
      done_pulses++;
      seen_done = 1'b1;
    end

    in_hs  = load && bus.s_in_valid && bus.m_dp_ready;
    out_hs = oen && bus.s_dp_valid && bus.m_out_ready;
    if (!req_rst && in_hs && (bus.s_in_last != (m_in == IN_LEN - 1))) m_err_len = 1'b1;

    if (req_rst) begin
      m_active = 0; m_done = 0; m_err_len = 0; m_err_to = 0;
      m_in = 0; m_out = 0; m_wd = 0; m_frames = 0;
    end else if (req_abort) begin
      m_active = 0; m_done = 0; m_in = 0; m_out = 0;
    end else if (m_done) begin
      m_done = 0; m_active = cont; m_in = 0; m_out = 0;
    end else if (!m_active) begin
      if (req_start) begin
        m_active = 1; m_in = 0; m_out = 0; m_err_len = 0; m_err_to = 0;
      end
    end else begin
      was_drain = (m_in == IN_LEN);
      m_in  += int'(in_hs);
      m_out += int'(out_hs);
      if (m_in == IN_LEN && m_out == OUT_LEN) begin
        m_active = 0; m_done = 1; m_frames++;
      end
`ifdef SEQ_TIMEOUT_EN
      else if (!was_drain || out_hs) m_wd = 0;
      else if (m_wd == TIMEOUT - 1) begin
        m_err_to = 1; m_active = 0; m_in = 0; m_out = 0; m_wd = 0;
      end else m_wd++;
`endif
    end
    req_start = 0;
    req_abort = 0;
    req_rst   = 0;
    @(posedge clock);
  endtask

  task automatic run_frame(input string tag, input int budget);
    seen_done = 1'b0;
    for (int n = 0; n < budget && !seen_done; n++) step();
    check({tag, "_done_seen"}, 32'(seen_done), 1);
  endtask

  initial begin
    int pulses0;
    RSTB = 1'b1; cfg_start = 0; cfg_continuous = 0; cfg_abort = 0;
    bus.s_in_valid = 0; bus.s_in_data = '0; bus.s_in_last = 0; bus.m_dp_ready = 0;
    bus.s_dp_valid = 0; bus.s_dp_data = '0; bus.s_dp_last = 0; bus.m_out_ready = 0;

    // Reset, then idle with all valids/readies driven high to prove the gating.
    req_rst = 1; step();
    req_rst = 1; step();
    chk_en = 1;
    step();
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_s_in_ready", bus.s_in_ready, 0);
    check("rst_m_out_valid", bus.m_out_valid, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    repeat (2) step();

    // Nominal frame with a slow datapath so DRAIN is exercised.
    p_ov = 60;
    req_start = 1;
    pulses0 = done_pulses;
    run_frame("nominal", 6000);
    repeat (3) step();
    check("nominal_frame_cnt", frame_cnt, 1);
    check("nominal_done_once", done_pulses - pulses0, 1);

    // Backpressure on both ready inputs.
    p_ov = 100; p_dr = 50; p_or = 50;
    req_start = 1;
    run_frame("backpressure", 9000);
    step();
    check("bp_frame_cnt", frame_cnt, 2);

    // Early s_in_last: error flagged, frame still ends on the internal count.
    p_dr = 100; p_or = 100; last_pos = 1000;
    req_start = 1;
    run_frame("len_err", 6000);
    step();
    check("len_err_flag", err_len, 1);
    last_pos = IN_LEN - 1;

    // Continuous mode: three back-to-back frames, each re-armed right after DONE.
    cont = 1;
    pulses0 = done_pulses;
    req_start = 1;
    for (int f = 0; f < 3; f++) begin
      run_frame("continuous", 6000);
      #1;
      check("cont_rearm_busy", busy, 1);
    end
    cont = 0; req_abort = 1; step();
    #1;
    check("cont_frame_cnt", frame_cnt, 6);
    check("cont_pulses", done_pulses - pulses0, 3);
    check("cont_err_len_cleared", err_len, 0);

    // Abort after 500 input bytes.
    req_start = 1;
    for (int n = 0; n < 2000 && m_in < 500; n++) step();
    check("abort_reached_500", m_in, 500);
    req_abort = 1; step();
    #1;
    check("abort_s_in_ready", bus.s_in_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_frame_cnt", frame_cnt, 6);

    // Synchronous reset at word 700 of DRAIN.
    p_ov = 20;
    req_start = 1;
    for (int n = 0; n < 12000 && !(m_in == IN_LEN && m_out >= 700); n++) step();
    check("drain_reached_700", 32'(m_in == IN_LEN && m_out >= 700), 1);
    p_ov = 100;
    req_rst = 1; step();
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_s_dp_ready", bus.s_dp_ready, 0);
    check("mid_rst_m_out_valid", bus.m_out_valid, 0);
    check("mid_rst_m_dp_valid", bus.m_dp_valid, 0);
    check("mid_rst_frame_cnt", frame_cnt, 0);
    step();

    // Datapath stalls after 100 output words.
    pulses0 = done_pulses;
    req_start = 1;
    for (int n = 0; n < 500 && m_out < 100; n++) step();
    check("stall_at_100", m_out, 100);
    p_ov = 0;
`ifdef SEQ_TIMEOUT_EN
    for (int n = 0; n < 9000 && err_timeout !== 1'b1; n++) step();
    check("wd_err_timeout", err_timeout, 1);
    check("wd_idle", busy, 0);
    check("wd_no_done", done_pulses - pulses0, 0);
`else
    repeat (IN_LEN + 5000) step();
    check("no_wd_still_busy", busy, 1);
    check("no_wd_err_timeout", err_timeout, 0);
    check("no_wd_no_done", done_pulses - pulses0, 0);
    req_abort = 1; step();
`endif
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
